// File: rtl/calc_core.sv
// calc_core: execution stage after the command decoder. Add/sub finish in a
// single pass; multiply and divide work on magnitudes, one bit per cycle.
module calc_core #(
    parameter int DW = 16,
    parameter int RW = 32
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic [3:0]    dtype,
    input  logic [4:0]    operator,
    input  logic [DW-1:0] src1,
    input  logic [DW-1:0] src2,
    input  logic          parser_done,
    output logic          busy,
    output logic [RW-1:0] result,
    output logic          err,
    output logic          calc_done
);

    localparam int CW = $clog2(DW);
    localparam logic [4:0]    OP_ADD   = 5'b00001;
    localparam logic [4:0]    OP_SUB   = 5'b00010;
    localparam logic [4:0]    OP_MUL   = 5'b00100;
    localparam logic [4:0]    OP_DIV   = 5'b01000;
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [DW:0]   MAG_ONE  = (DW + 1)'(1);
    localparam logic [RW-1:0] RES_ONE  = RW'(1);
    localparam logic [RW-1:0] RES_ZERO = RW'(0);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t        state_r;
    state_t        next_state_s;
    logic [CW-1:0] cnt_r;
    logic [3:0]    dtype_r;
    logic [4:0]    op_r;
    logic [DW-1:0] src1_r;
    logic [DW-1:0] src2_r;
    logic          neg_r;
    logic          iter_op_r;
    logic [RW-1:0] mcand_r;
    logic [DW-1:0] mplier_r;
    logic [RW-1:0] acc_r;
    logic [DW-1:0] quot_r;
    logic [DW:0]   rem_r;
    logic [DW:0]   divisor_r;
    logic [RW-1:0] result_r;
    logic          err_r;
    logic          calc_done_r;
    logic          busy_r;

    logic          is_signed_s;
    logic          dtype_ok_s;
    logic          op_ok_s;
    logic          div_zero_s;
    logic          cmd_err_s;
    logic          addsub_s;
    logic [RW-1:0] ext1_s;
    logic [RW-1:0] ext2_s;
    logic [RW-1:0] sum_s;
    logic [DW:0]   sx1_s;
    logic [DW:0]   sx2_s;
    logic [DW:0]   mag1_s;
    logic [DW:0]   mag2_s;
    logic [DW+1:0] rem_sh_s;
    logic [DW+1:0] rem_diff_s;
    logic          fits_s;
    logic [RW-1:0] mag_res_s;
    logic [RW-1:0] fixed_s;

    assign is_signed_s = (dtype_r == 4'd1);
    assign dtype_ok_s  = (dtype_r == 4'd0) || is_signed_s;
    assign op_ok_s     = (op_r == OP_ADD) || (op_r == OP_SUB) ||
                         (op_r == OP_MUL) || (op_r == OP_DIV);
    assign div_zero_s  = (op_r == OP_DIV) && (src2_r == {DW{1'b0}});
    assign cmd_err_s   = !dtype_ok_s || !op_ok_s || div_zero_s;
    assign addsub_s    = (op_r == OP_ADD) || (op_r == OP_SUB);

    assign ext1_s = {{(RW-DW){is_signed_s & src1_r[DW-1]}}, src1_r};
    assign ext2_s = {{(RW-DW){is_signed_s & src2_r[DW-1]}}, src2_r};
    assign sum_s  = (op_r == OP_SUB) ? (ext1_s - ext2_s) : (ext1_s + ext2_s);

    // One extra bit keeps the magnitude of the most negative operand representable.
    assign sx1_s  = {is_signed_s & src1_r[DW-1], src1_r};
    assign sx2_s  = {is_signed_s & src2_r[DW-1], src2_r};
    assign mag1_s = sx1_s[DW] ? (~sx1_s + MAG_ONE) : sx1_s;
    assign mag2_s = sx2_s[DW] ? (~sx2_s + MAG_ONE) : sx2_s;

    // Restoring step: a borrow out of the top bit means the divisor did not fit.
    assign rem_sh_s   = {rem_r, quot_r[DW-1]};
    assign rem_diff_s = rem_sh_s - {1'b0, divisor_r};
    assign fits_s     = !rem_diff_s[DW+1];

    assign mag_res_s = (op_r == OP_MUL) ? acc_r : {{(RW-DW){1'b0}}, quot_r};
    assign fixed_s   = neg_r ? (~mag_res_s + RES_ONE) : mag_res_s;

    // Next-state decode for the command sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (parser_done) next_state_s = PREP;
                else             next_state_s = IDLE;
            end
            PREP: begin
                if (cmd_err_s || addsub_s) next_state_s = FIX;
                else                       next_state_s = ITER;
            end
            ITER: begin
                if (cnt_r == CNT_LAST) next_state_s = FIX;
                else                   next_state_s = ITER;
            end
            FIX:     next_state_s = DONE;
            DONE:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register with busy/calc_done registered from the next state.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            calc_done_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            busy_r      <= (next_state_s != IDLE);
            calc_done_r <= (next_state_s == DONE);
        end
    end

    // Operand capture, arithmetic datapath and result/err registers.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt_r     <= {CW{1'b0}};
            dtype_r   <= 4'd0;
            op_r      <= 5'd0;
            src1_r    <= {DW{1'b0}};
            src2_r    <= {DW{1'b0}};
            neg_r     <= 1'b0;
            iter_op_r <= 1'b0;
            mcand_r   <= RES_ZERO;
            mplier_r  <= {DW{1'b0}};
            acc_r     <= RES_ZERO;
            quot_r    <= {DW{1'b0}};
            rem_r     <= {(DW+1){1'b0}};
            divisor_r <= {(DW+1){1'b0}};
            result_r  <= RES_ZERO;
            err_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (parser_done) begin
                        dtype_r <= dtype;
                        op_r    <= operator;
                        src1_r  <= src1;
                        src2_r  <= src2;
                    end
                end
                PREP: begin
                    if (cmd_err_s) begin
                        err_r     <= 1'b1;
                        result_r  <= RES_ZERO;
                        iter_op_r <= 1'b0;
                    end else if (addsub_s) begin
                        err_r     <= 1'b0;
                        result_r  <= sum_s;
                        iter_op_r <= 1'b0;
                    end else begin
                        err_r     <= 1'b0;
                        iter_op_r <= 1'b1;
                        neg_r     <= is_signed_s & (src1_r[DW-1] ^ src2_r[DW-1]);
                        mcand_r   <= {{(RW-DW-1){1'b0}}, mag1_s};
                        mplier_r  <= mag2_s[DW-1:0];
                        acc_r     <= RES_ZERO;
                        quot_r    <= mag1_s[DW-1:0];
                        rem_r     <= {(DW+1){1'b0}};
                        divisor_r <= mag2_s;
                        cnt_r     <= {CW{1'b0}};
                    end
                end
                ITER: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (op_r == OP_MUL) begin
                        acc_r    <= acc_r + (mplier_r[0] ? mcand_r : RES_ZERO);
                        mcand_r  <= {mcand_r[RW-2:0], 1'b0};
                        mplier_r <= {1'b0, mplier_r[DW-1:1]};
                    end else begin
                        quot_r <= {quot_r[DW-2:0], fits_s};
                        rem_r  <= fits_s ? rem_diff_s[DW:0] : rem_sh_s[DW:0];
                    end
                end
                FIX: begin
                    if (iter_op_r) result_r <= fixed_s;
                end
                DONE: begin
                    cnt_r <= {CW{1'b0}};
                end
                default: begin
                    cnt_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign result    = result_r;
    assign err       = err_r;
    assign calc_done = calc_done_r;

endmodule

// File: doc/calc_core.md
Name: calc_core

Overview:
- Execution stage directly downstream of the UART command decoder.
- On `parser_done`, it captures `dtype`, `operator`, `src1` and `src2`, and runs the requested arithmetic. Add and subtract take one pass; multiply and divide are iterative over 16 steps.
- It presents a 32-bit result with a one-cycle `calc_done` pulse to the response formatter / UART TX stage.

Parameters:
- `DW`, 16, operand width; the iteration count equals `DW`.
- `RW`, 32, result width (`2*DW`).

Ports:
- `clk`  input  1  system clock, rising edge.
- `n_rst`  input  1  reset, synchronous, active-low.
- `dtype`  input  4  4'd0 = unsigned, 4'd1 = signed; any other value is invalid.
- `operator`  input  5  one-hot: 5'b00001 = add, 5'b00010 = sub, 5'b00100 = mul, 5'b01000 = div; any other value is invalid.
- `src1`  input  `DW`  first operand.
- `src2`  input  `DW`  second operand.
- `parser_done`  input  1  single-cycle strobe; inputs are valid in the same cycle.
- `busy`  output  1  high whenever the state is not IDLE.
- `result`  output  `RW`  computed value, two's complement.
- `err`  output  1  invalid `dtype`/`operator`, or divide by zero.
- `calc_done`  output  1  one-cycle pulse; `result` and `err` are valid from this cycle.

Behaviour:
- **Reset:** synchronous. When `n_rst` is 0 at a rising edge:
  - state goes to IDLE and the iteration counter is cleared;
  - `result`, `err`, `calc_done` and `busy` are all 0.
  - Reset applied mid-operation abandons the operation; no `calc_done` is produced.
- **States:** IDLE, PREP, ITER, FIX, DONE.
- **IDLE:**
  - When `parser_done` is 1: register all inputs, go to PREP.
  - Otherwise stay in IDLE.
- **PREP:**
  - Invalid `dtype` or `operator`: set `err`=1, `result`=0, go to FIX.
  - Div with `src2`=0: set `err`=1, `result`=0, go to FIX.
  - Add/sub:
    - Signed: sign-extend both operands to `RW`.
    - Unsigned: zero-extend both operands to `RW`.
    - Compute sum or difference modulo 2^`RW`, then go to FIX.
  - Mul/div:
    - Form 17-bit magnitudes: the absolute value when signed, the raw value when unsigned. This keeps -32768 representable.
    - Record the result sign: XOR of the operand signs when signed, 0 when unsigned.
    - Clear the counter, go to ITER.
- **ITER:**
  - Mul uses shift-add with one multiplier bit per cycle, LSB first.
  - Div uses restoring shift-subtract with one quotient bit per cycle, MSB first. The remainder is internal only.
  - After the 16th iteration, go to FIX.
- **FIX:** apply negation to the magnitude result when the sign flag is set, then go to DONE. Add/sub/error results pass through unchanged.
- **DONE:**
  - `calc_done` is 1 for exactly this cycle; next state is IDLE.
- **Division semantics:** truncation toward zero; only the quotient is reported. -32768 / -1 = +32768 (0x00008000); there is no overflow.
- **Widths:** the mul result occupies the full `RW` bits. No operation can overflow `RW`.
- **Latency:** counted from the edge that samples `parser_done` (edge 0).
  - Add, sub, error: `calc_done` is high after edge 2.
  - Mul, div: `calc_done` is high after edge 18.
- **`parser_done` while `busy`=1:** including in DONE, it is ignored. There is no queueing and state is unaffected.
- **Output holding:** `result` and `err` hold their values from `calc_done` until the next capture in PREP. `err` is cleared in PREP for a valid command.
- **Simultaneous events:** `n_rst`=0 and `parser_done`=1 in the same cycle means reset wins and nothing is captured.

Test Plan:
- Unsigned add, `dtype`=0, 1234+5678 (0x04D2, 0x162E) → `result`=0x00001B00, `err`=0, `calc_done` 2 cycles after the strobe, `busy` high for 3 cycles.
- Unsigned mul, 1234*5678 → `result`=0x006AE9BC at 18 cycles. Then issue a second `parser_done` during ITER with 1+1 → ignored: only one `calc_done`, result unchanged.
- Signed cases, `dtype`=1:
  - 0x0005−0x0010 → 0xFFFFFFF5;
  - 0xFFFD*0x0004 (−3*4) → 0xFFFFFFF4;
  - 0xFF9C/0x0007 (−100/7) → 0xFFFFFFF2 (−14);
  - 0x8000/0xFFFF → 0x00008000.
- Errors:
  - Div 1234/0 → `err`=1, `result`=0, `calc_done` at 2 cycles.
  - `operator`=5'b10000 → `err`=1.
  - `dtype`=4'd7 → `err`=1.
  - A following valid add clears `err`.
- Reset: drive `n_rst`=0 at ITER iteration 8 of a div → next cycle state is IDLE and all outputs are 0, with no `calc_done`. A new command after reset completes normally.
